mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares one unified memory port between instruction fetch (I port) and load/store (D port) of the RV32I core. A 2-state FSM grants one requester at a time, holds the access to memory until the memory acknowledges, then returns read data or a write ack to the owner. D has fixed priority by default; round-robin is an optional build feature.

Parameters:
ADDR_W, 32, address width of both ports and memory.
DATA_W, 32, data width of both ports and memory.

Ports:
clk  in  1  core clock, all state on rising edge.
rst  in  1  synchronous, active-high reset.
i_req  in  1  fetch request; held with i_addr stable until i_gnt.
i_addr  in  ADDR_W  fetch address.
i_gnt  out  1  combinational; request accepted this cycle.
i_rvalid  out  1  registered 1-cycle pulse; i_rdata valid.
i_rdata  out  DATA_W  fetched instruction.
d_req  in  1  load/store request; held with d_addr/d_we/d_wdata/d_size stable until d_gnt.
d_addr  in  ADDR_W  load/store address.
d_we  in  1  1 = store, 0 = load.
d_wdata  in  DATA_W  store data.
d_size  in  3  funct3 size/sign code, passed through.
d_gnt  out  1  combinational; request accepted this cycle.
d_rvalid  out  1  registered 1-cycle pulse; load data or store ack.
d_rdata  out  DATA_W  load data; 0 on store ack.
mem_req  out  1  registered; access in progress.
mem_addr  out  ADDR_W  registered latched address.
mem_we  out  1  registered latched write enable.
mem_wdata  out  DATA_W  registered latched store data.
mem_size  out  3  registered latched size code.
mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
mem_ready  in  1  memory completes the current access this cycle.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; mem_req, mem_we, i_rvalid, d_rvalid = 0; mem_addr, mem_wdata, mem_size, i_rdata, d_rdata = 0; owner=I; last_owner=I.
- Reset mid-access: the access is abandoned, no rvalid is produced, and mem_req drops after that edge.
- IDLE: gnt to winner only. With both requests: d_gnt=1 and i_gnt=0 (fixed priority). On the edge: latch addr/we/wdata/size and owner, mem_req<=1, state->ACTIVE.
- I-port latch: mem_we<=0, mem_wdata<=0, mem_size<=3'b010 (word).
- ACTIVE: both gnt=0. Requests are ignored and wait. mem_* held stable until mem_ready=1.
- ACTIVE with mem_ready=1 at the edge: owner rvalid<=1, owner rdata<=mem_rdata (load/fetch) or 0 (store), mem_req<=0, mem_we<=0, state->IDLE.
- rvalid is exactly one cycle. Non-owner rdata keeps its last value.
- Latency: gnt in cycle N, mem_req from N+1, mem_ready in cycle M>=N+1, rvalid in M+1. A new gnt is allowed in M+1, the same cycle as rvalid. Best-case throughput is one access per 2 cycles.
- A requester may drop req before gnt with no effect. Requests are never queued internally.
- mem_ready while IDLE is ignored.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: round-robin on contention. The winner is the port other than last_owner, which updates on every grant. Reset last_owner=I, so D wins the first tie. Neither port can starve.
- Undefined: fixed D>I priority. last_owner is not implemented. I may starve under back-to-back D requests.

Decomposition:
- Package mem_arb_pkg holds: state encoding (IDLE, ACTIVE); owner encoding (OWN_I=0, OWN_D=1); size constants SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101.
- One natural sub-module, mem_arb_pick: combinational winner select from i_req, d_req, state and last_owner. It produces i_gnt and d_gnt.

Test Plan:
- Reset, then i_req=1, i_addr=0x100, mem_ready tied 1, mem_rdata=0x00500093 -> i_gnt in cycle 1; mem_req=1 with mem_addr=0x100, mem_size=010 in cycle 2; i_rvalid=1 with i_rdata=0x00500093 in cycle 3.
- i_req and d_req (load, 0x2000, size 100) in the same cycle -> d_gnt=1, i_gnt=0. I is granted in the cycle D's rvalid pulses. With MEM_ARB_RR_EN and a second tie, I wins.
- Store d_we=1, addr 0x40, wdata 0xDEADBEEF, mem_ready delayed 3 cycles -> mem_* stable for all 3 cycles; d_rvalid=1 with d_rdata=0; mem_we=0 afterwards.
- Continuous d_req for 10 accesses with i_req held -> i_gnt never asserts in the default build. With MEM_ARB_RR_EN, grants alternate D, I, D, I.
- rst=1 while ACTIVE before mem_ready -> next cycle mem_req=0, no rvalid, state IDLE. A subsequent i_req is granted normally.
- mem_ready=1 while IDLE, and i_req dropped before grant -> no gnt, no rvalid, mem_req stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D unified memory port arbiter.
// Build option MEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed D>I priority.
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // RV32I funct3 load/store size codes; the arbiter passes them through untouched.
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    function automatic owner_t other_owner(input owner_t owner);
        return (owner == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter; grants only while the port is idle.
// With MEM_ARB_RR_EN defined, ties go to the port that did not own the previous access.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_fetch_req,
    input  logic   i_ls_req,
    input  state_t i_state,
`ifdef MEM_ARB_RR_EN
    input  owner_t i_last_owner,
`endif
    output logic   o_fetch_gnt,
    output logic   o_ls_gnt
);

    always_comb begin
        o_fetch_gnt = 1'b0;
        o_ls_gnt    = 1'b0;
        if (i_state == IDLE) begin
            if (i_fetch_req && i_ls_req) begin
`ifdef MEM_ARB_RR_EN
                o_ls_gnt    = (other_owner(i_last_owner) == OWN_D);
                o_fetch_gnt = !o_ls_gnt;
`else
                o_ls_gnt    = 1'b1;
`endif
            end else begin
                o_ls_gnt    = i_ls_req;
                o_fetch_gnt = i_fetch_req;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D), one access at a time.
// Define MEM_ARB_RR_EN for round-robin on contention; default is fixed D>I priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_size,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t            r_state;
    state_t            w_next_state;
    owner_t            r_owner;
    logic              w_i_gnt;
    logic              w_d_gnt;
    logic              w_done;

    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [2:0]        r_mem_size;
    logic              r_i_rvalid;
    logic [DATA_W-1:0] r_i_rdata;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;

`ifdef MEM_ARB_RR_EN
    owner_t            r_last_owner;
`endif

    mem_arb_pick u_pick (
        .i_fetch_req  (i_req),
        .i_ls_req     (d_req),
        .i_state      (r_state),
`ifdef MEM_ARB_RR_EN
        .i_last_owner (r_last_owner),
`endif
        .o_fetch_gnt  (w_i_gnt),
        .o_ls_gnt     (w_d_gnt)
    );

    assign w_done = (r_state == ACTIVE) && mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_i_gnt || w_d_gnt) w_next_state = ACTIVE;
            ACTIVE:  if (mem_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Grants only happen in IDLE and completions only in ACTIVE, so the branches never overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= OWN_I;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_size  <= '0;
            r_i_rvalid  <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            if (w_d_gnt) begin
                r_owner     <= OWN_D;
                r_mem_req   <= 1'b1;
                r_mem_addr  <= d_addr;
                r_mem_we    <= d_we;
                r_mem_wdata <= d_wdata;
                r_mem_size  <= d_size;
            end else if (w_i_gnt) begin
                r_owner     <= OWN_I;
                r_mem_req   <= 1'b1;
                r_mem_addr  <= i_addr;
                r_mem_we    <= 1'b0;
                r_mem_wdata <= '0;
                r_mem_size  <= SZ_W;
            end else if (w_done) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (r_owner == OWN_D) begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= r_mem_we ? '0 : mem_rdata;
                end else begin
                    r_i_rvalid <= 1'b1;
                    r_i_rdata  <= mem_rdata;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= OWN_I;
        end else if (w_d_gnt) begin
            r_last_owner <= OWN_D;
        end else if (w_i_gnt) begin
            r_last_owner <= OWN_I;
        end
    end
`endif

    assign i_gnt     = w_i_gnt;
    assign d_gnt     = w_d_gnt;
    assign i_rvalid  = r_i_rvalid;
    assign i_rdata   = r_i_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign mem_size  = r_mem_size;

endmodule
